// File: rtl/acc_readout_if.sv
// Bus between the accumulator control side and acc_readout_scheduler.
// master drives window control and accumulator data; slave is the scheduler.
interface acc_readout_if #(
    parameter int ACC_WIDTH = 16,
    parameter int NUM_CH    = 4
);
    logic                        enable;
    logic                        sample_en;
    logic [15:0]                 ds_ratio;
    logic [NUM_CH*ACC_WIDTH-1:0] acc_data;
    logic                        frame_latch;
    logic                        serial_start;
    logic                        serial_out;
    logic                        busy;
    logic                        overrun;

    modport master (
        output enable, sample_en, ds_ratio, acc_data,
        input  frame_latch, serial_start, serial_out, busy, overrun
    );

    modport slave (
        input  enable, sample_en, ds_ratio, acc_data,
        output frame_latch, serial_start, serial_out, busy, overrun
    );
endinterface

// File: rtl/acc_readout_scheduler.sv
// Window counter, single shadow frame buffer and MSB-first serial shifter for the accumulator bank.
// Define ACC_READOUT_PARITY_EN to append an even-parity bit after the payload.
module acc_readout_scheduler #(
    parameter int ACC_WIDTH = 16,
    parameter int NUM_CH    = 4
) (
    input  logic         clk,
    input  logic         reset,
    acc_readout_if.slave bus
);
    localparam int PAYLOAD_W = NUM_CH * ACC_WIDTH;
`ifdef ACC_READOUT_PARITY_EN
    localparam int FRAME_LEN = PAYLOAD_W + 1;
`else
    localparam int FRAME_LEN = PAYLOAD_W;
`endif
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2
    } state_t;

    function automatic logic [15:0] clamp_ratio(input logic [15:0] r);
        return (r == 16'd0) ? 16'd1 : r;
    endfunction

    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [PAYLOAD_W-1:0] p);
`ifdef ACC_READOUT_PARITY_EN
        return {p, ^p};
`else
        return p;
`endif
    endfunction

    logic [15:0]           win_cnt;
    logic [15:0]           eff_ratio;
    logic [15:0]           ratio_cur;
    logic                  win_done;
    logic                  latch_q;

    logic [PAYLOAD_W-1:0]  shadow_q;
    logic                  shadow_valid;
    logic                  overrun_q;
    logic                  consume;

    state_t                state;
    logic [FRAME_LEN-1:0]  shift_q;
    logic [IDX_W-1:0]      bit_idx;
    logic                  start_q;
    logic                  sout_q;
    logic                  busy_q;

    // The ratio is only re-read at the start of a window; mid-window changes wait for the boundary.
    assign ratio_cur = (win_cnt == 16'd0) ? clamp_ratio(bus.ds_ratio) : eff_ratio;
    assign win_done  = bus.enable && bus.sample_en && (win_cnt == ratio_cur - 16'd1);
    assign consume   = shadow_valid && ((state == IDLE) ||
                                        ((state == SHIFT) && (bit_idx == '0)));

    // Window counter and latch strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt   <= 16'd0;
            eff_ratio <= 16'd1;
            latch_q   <= 1'b0;
        end else begin
            latch_q <= win_done;
            if (win_cnt == 16'd0)
                eff_ratio <= ratio_cur;
            if (!bus.enable)
                win_cnt <= 16'd0;
            else if (bus.sample_en)
                win_cnt <= win_done ? 16'd0 : win_cnt + 16'd1;
        end
    end

    // Shadow frame buffer; a latch that finds it full and unconsumed is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q     <= '0;
            shadow_valid <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (latch_q) begin
            if (!shadow_valid || consume) begin
                shadow_q     <= bus.acc_data;
                shadow_valid <= 1'b1;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (consume) begin
            shadow_valid <= 1'b0;
        end
    end

    // Shifter FSM; outputs are registered alongside the state they belong to
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shift_q <= '0;
            bit_idx <= '0;
            start_q <= 1'b0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sout_q <= 1'b0;
                    if (shadow_valid) begin
                        shift_q <= build_frame(shadow_q);
                        state   <= START;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        start_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    sout_q  <= shift_q[FRAME_LEN-1];
                    shift_q <= shift_q << 1;
                    bit_idx <= IDX_W'(FRAME_LEN - 1);
                    busy_q  <= 1'b1;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (bit_idx != '0) begin
                        sout_q  <= shift_q[FRAME_LEN-1];
                        shift_q <= shift_q << 1;
                        bit_idx <= bit_idx - IDX_W'(1);
                    end else if (shadow_valid) begin
                        shift_q <= build_frame(shadow_q);
                        sout_q  <= 1'b0;
                        start_q <= 1'b1;
                        state   <= START;
                    end else begin
                        sout_q <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    start_q <= 1'b0;
                    sout_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.frame_latch  = latch_q;
    assign bus.serial_start = start_q;
    assign bus.serial_out   = sout_q;
    assign bus.busy         = busy_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_acc_readout_scheduler.sv
// Directed bench for acc_readout_scheduler; builds with or without ACC_READOUT_PARITY_EN.
module tb_acc_readout_scheduler;
    localparam int ACC_WIDTH = 16;
    localparam int NUM_CH    = 4;
`ifdef ACC_READOUT_PARITY_EN
    localparam int FRAME_LEN = 65;
`else
    localparam int FRAME_LEN = 64;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   lat_q[$];

    acc_readout_if #(.ACC_WIDTH(ACC_WIDTH), .NUM_CH(NUM_CH)) io();

    acc_readout_scheduler #(.ACC_WIDTH(ACC_WIDTH), .NUM_CH(NUM_CH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (io.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (io.frame_latch === 1'b1) lat_q.push_back(cyc);
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        io.enable    = 1'b0;
        io.sample_en = 1'b0;
        io.ds_ratio  = 16'd0;
        io.acc_data  = '0;
        step();
        step();
        reset = 1'b0;
        lat_q.delete();
    endtask

    task automatic wait_start(input string tag, input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (io.serial_start !== 1'b1 && k < budget);
        check_eq({tag, "_start_seen"}, 64'(io.serial_start), 64'd1);
    endtask

    task automatic capture_bits(output logic [FRAME_LEN-1:0] bits);
        bits = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            step();
            bits = {bits[FRAME_LEN-2:0], io.serial_out};
        end
    endtask

    initial begin
        logic [FRAME_LEN-1:0] fr;
        int s1;
        int bad;
        int base;

        io.enable    = 1'b0;
        io.sample_en = 1'b0;
        io.ds_ratio  = 16'd0;
        io.acc_data  = '0;

        // reset state
        apply_reset();
        check_eq("rst_frame_latch", 64'(io.frame_latch), 64'd0);
        check_eq("rst_serial_start", 64'(io.serial_start), 64'd0);
        check_eq("rst_serial_out", 64'(io.serial_out), 64'd0);
        check_eq("rst_busy", 64'(io.busy), 64'd0);
        check_eq("rst_overrun", 64'(io.overrun), 64'd0);

        // samples while disabled never close a window
        io.sample_en = 1'b1;
        io.ds_ratio  = 16'd2;
        repeat (10) step();
        check_eq("disabled_no_latch", 64'(lat_q.size()), 64'd0);
        check_eq("disabled_idle", 64'(io.busy), 64'd0);

        // basic window, ratio 4
        apply_reset();
        io.ds_ratio  = 16'd4;
        io.acc_data  = 64'h1234_5678_9ABC_DEF0;
        io.enable    = 1'b1;
        io.sample_en = 1'b1;
        wait_start("basic", 20);
        s1 = cyc;
        check_eq("basic_start_bit_zero", 64'(io.serial_out), 64'd0);
        check_eq("basic_latch_to_start", 64'(s1 - lat_q[0]), 64'd2);
        capture_bits(fr);
        check_eq("basic_payload", fr[FRAME_LEN-1 -: 64], 64'h1234_5678_9ABC_DEF0);
        check_eq("basic_latch_period", 64'(lat_q[1] - lat_q[0]), 64'd4);
        check_eq("basic_busy_last_bit", 64'(io.busy), 64'd1);
        check_eq("basic_overrun_set", 64'(io.overrun), 64'd1);

        // reset in the middle of a frame
        apply_reset();
        io.ds_ratio  = 16'd4;
        io.acc_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        io.enable    = 1'b1;
        io.sample_en = 1'b1;
        wait_start("midrst", 20);
        repeat (21) step();
        check_eq("midrst_busy_before", 64'(io.busy), 64'd1);
        reset = 1'b1;
        step();
        check_eq("midrst_serial_out", 64'(io.serial_out), 64'd0);
        check_eq("midrst_serial_start", 64'(io.serial_start), 64'd0);
        check_eq("midrst_busy", 64'(io.busy), 64'd0);
        check_eq("midrst_overrun", 64'(io.overrun), 64'd0);
        check_eq("midrst_frame_latch", 64'(io.frame_latch), 64'd0);
        reset     = 1'b0;
        io.enable = 1'b0;
        bad = 0;
        for (int k = 0; k < 80; k++) begin
            step();
            if (io.serial_out !== 1'b0 || io.serial_start !== 1'b0 || io.busy !== 1'b0) bad++;
        end
        check_eq("midrst_quiet_after", 64'(bad), 64'd0);

        // ratio 0 behaves as 1
        apply_reset();
        io.ds_ratio  = 16'd0;
        io.acc_data  = 64'hA5A5_0000_5A5A_FFFF;
        io.enable    = 1'b1;
        io.sample_en = 1'b1;
        step();
        check_eq("r0_latch_1", 64'(io.frame_latch), 64'd1);
        step();
        check_eq("r0_latch_2", 64'(io.frame_latch), 64'd1);
        check_eq("r0_overrun_2", 64'(io.overrun), 64'd0);
        step();
        check_eq("r0_start", 64'(io.serial_start), 64'd1);
        check_eq("r0_overrun_3", 64'(io.overrun), 64'd0);
        step();
        check_eq("r0_overrun_4", 64'(io.overrun), 64'd1);

        // back-to-back frames with ratio = frame period
        apply_reset();
        io.ds_ratio  = 16'(FRAME_LEN + 1);
        io.acc_data  = 64'hC3C3_3C3C_0F0F_F0F0;
        io.enable    = 1'b1;
        io.sample_en = 1'b1;
        wait_start("b2b", 200);
        bad = 0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 1; k <= FRAME_LEN; k++) begin
                step();
                if (io.busy !== 1'b1) bad++;
                if (io.serial_start !== 1'b0) bad++;
            end
            step();
            check_eq("b2b_start_gap", 64'(io.serial_start), 64'd1);
        end
        check_eq("b2b_busy_continuous", 64'(bad), 64'd0);
        check_eq("b2b_overrun", 64'(io.overrun), 64'd0);

        // ratio change 8 -> 3 at count 5
        apply_reset();
        io.ds_ratio  = 16'd8;
        io.enable    = 1'b1;
        io.sample_en = 1'b1;
        base = cyc;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 5) io.ds_ratio = 16'd3;
        end
        check_eq("ratio_first_window", 64'(lat_q[0] - base), 64'd8);
        check_eq("ratio_second_window", 64'(lat_q[1] - base), 64'd11);

`ifdef ACC_READOUT_PARITY_EN
        // parity bit trails the payload
        apply_reset();
        io.ds_ratio  = 16'd1;
        io.acc_data  = 64'h1;
        io.enable    = 1'b1;
        io.sample_en = 1'b1;
        step();
        io.sample_en = 1'b0;
        wait_start("par1", 10);
        capture_bits(fr);
        check_eq("parity_odd_ones", 64'(fr[0]), 64'd1);
        io.acc_data  = 64'h3;
        io.sample_en = 1'b1;
        step();
        io.sample_en = 1'b0;
        wait_start("par3", 10);
        capture_bits(fr);
        check_eq("parity_even_ones", 64'(fr[0]), 64'd0);
        check_eq("parity_payload", fr[FRAME_LEN-1 -: 64], 64'h3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
